// File: rtl/write_full_ctrl.sv
// write_full_ctrl: write-side pointer and flag controller for an asynchronous FIFO.
// Keeps the binary and Gray write pointers and drives the RAM write address and enable.
// It also produces a registered full flag, an almost-full flag, a pessimistic fill level
// and a sticky overflow flag. All of these are derived from the read pointer, which has
// already been synchronised into the write clock domain.
// FIFO_addr_size is log2 of the FIFO depth, with a legal range of 2..12.
module write_full_ctrl #(
    parameter int FIFO_addr_size = 4
) (
    input  logic                      clk_w,
    input  logic                      rst_w,
    input  logic                      w_en,
    input  logic [FIFO_addr_size:0]   r_pointer_gray_sync,
    input  logic [FIFO_addr_size:0]   afull_level,
    input  logic                      ovf_clr,
    output logic                      w_ack,
    output logic [FIFO_addr_size-1:0] w_addr,
    output logic [FIFO_addr_size:0]   w_pointer_gray,
    output logic                      full,
    output logic                      almost_full,
    output logic [FIFO_addr_size:0]   wr_level,
    output logic                      overflow
);

    localparam int PW = FIFO_addr_size + 1;

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Reflected Gray code to binary, resolved from the MSB downwards.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] w_bin_q,  w_bin_d;
    logic [PW-1:0] w_gray_q, w_gray_d;
    logic          full_q,   full_d;
    logic          afull_q,  afull_d;
    logic [PW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic          w_ack_s;
    logic [PW-1:0] r_bin_s;
    logic [PW-1:0] full_cmp_s;

    // Accept a write only when not full and not held in reset.
    assign w_ack_s = w_en & ~full_q & rst_w;

    // Next-state computation. The pointer advances first, and then every flag is
    // derived from the advanced pointer. This gives zero-cycle flag latency after
    // the last write.
    always_comb begin
        w_bin_d    = w_bin_q + {{(PW-1){1'b0}}, w_ack_s};
        w_gray_d   = bin2gray(w_bin_d);
        r_bin_s    = gray2bin(r_pointer_gray_sync);
        // The FIFO is full when the write pointer is exactly one lap ahead of the
        // read pointer. In Gray code, that means the top two bits differ and the
        // remaining bits are equal.
        full_cmp_s = {~r_pointer_gray_sync[PW-1:PW-2], r_pointer_gray_sync[PW-3:0]};
        full_d     = (w_gray_d == full_cmp_s);
        // The subtraction is modulo 2^PW. The read pointer never passes the write
        // pointer, so the difference never underflows. It can only overstate the
        // fill level, because the read pointer is seen late.
        level_d    = w_bin_d - r_bin_s;
        if (afull_level != {PW{1'b0}}) begin
            afull_d = (level_d >= afull_level);
        end else begin
            afull_d = 1'b0;
        end
        // An attempted write while full sets the overflow flag, and a set in the
        // same cycle as a clear takes priority.
        if (w_en && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_w) begin
        if (!rst_w) begin
            w_bin_q  <= {PW{1'b0}};
            w_gray_q <= {PW{1'b0}};
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            level_q  <= {PW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_gray_q <= w_gray_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign w_ack          = w_ack_s;
    assign w_addr         = w_bin_q[FIFO_addr_size-1:0];
    assign w_pointer_gray = w_gray_q;
    assign full           = full_q;
    assign almost_full    = afull_q;
    assign wr_level       = level_q;
    assign overflow       = ovf_q;

endmodule
